trackball_decoder: RTL and testbench
====================================

# trackball_decoder

Parametrised, fully synchronous successor to the per-player trackball front end. It samples the raw trackball direction/strobe lines for every player and axis through synchronisers, selects one player's lines, and counts strobe rising edges up or down per axis in wrap or saturate mode. It also provides a CPU-facing snapshot latch with sticky overflow flags. It sits between the cabinet input pins and the CPU input-port mux, replacing the old counters that were clocked directly by the trackball lines.

## Interface
- `NUM_AXES`, 2: axes per player (horizontal, vertical, ...).
- `NUM_PLAYERS`, 2: trackball sets; `PSEL_W = $clog2(NUM_PLAYERS)`, minimum 1.
- `CNT_W`, 4: counter width per axis.
- `SYNC_STAGES`, 2: synchroniser depth, ≥2.
- `MODE`, `CNT_WRAP`: `CNT_WRAP` or `CNT_SAT`.

- `clk` in 1: single system clock; all state on posedge.
- `rstclr_l` in 1: reset, asynchronous assert, active-low.
- `dir_in` in NUM_PLAYERS*NUM_AXES: raw direction, bit index p*NUM_AXES+a.
- `stb_in` in NUM_PLAYERS*NUM_AXES: raw strobe (former trackball clock), same indexing.
- `player_sel` in PSEL_W: selected player (generalised flip); out-of-range values select player 0.
- `steerclr` in 1: synchronous clear of all counters and ovf flags.
- `snap` in 1: one-cycle snapshot request.
- `dir_out` out NUM_AXES: direction latched at last counted edge, per axis.
- `cnt` out NUM_AXES*CNT_W: live counts, axis a at [a*CNT_W +: CNT_W].
- `ovf` out NUM_AXES: sticky wrap/saturation flag.
- `snap_cnt` out NUM_AXES*CNT_W: snapshot of cnt.
- `snap_ovf` out NUM_AXES: snapshot of ovf.
- `snap_valid` out 1: one-cycle pulse, snapshot registers updated.

## Operation
- Each `dir_in`/`stb_in` bit passes through its own SYNC_STAGES flop chain, so dir and stb of a channel have equal latency.
- Per channel, a `prev` flop holds the last synced strobe. A rise is synced stb=1 with prev=0. All channels are tracked continuously, so changing `player_sel` never creates a false edge.
- Axis a counts only on a rise of channel (player_sel, a). It uses the synced dir of that channel in the same cycle: 0 = up (+1), 1 = down (−1). That dir value is also latched into `dir_out[a]`.
- `CNT_WRAP`: modulo 2^CNT_W. A wrap in either direction sets `ovf[a]`.
- `CNT_SAT`: holds at max (all ones) or 0. A count attempted at the limit is dropped and sets `ovf[a]`.
- Precedence per cycle: `steerclr` > count edge. With steerclr, `cnt`=0 and `ovf`=0 next cycle and the edge is discarded. `dir_out` still updates on that edge.
- `snap`: `snap_cnt`/`snap_ovf` take the current registered `cnt`/`ovf` (the pre-update value of this cycle), and `snap_valid`=1 next cycle.
- snap also clears `ovf`. If a new overflow occurs in the same cycle, ovf stays set (set wins). snap together with steerclr: the snapshot gets the pre-clear values and both clears apply.
- Reset: all sync, prev, `cnt`, `dir_out`, `ovf`, `snap_cnt`, `snap_ovf`, `snap_valid` = 0.

## Timing
- If `stb_in` rises before posedge k, the synced stb is high after posedge k+SYNC_STAGES−1 and `cnt` updates at posedge k+SYNC_STAGES. Total latency is SYNC_STAGES+1 edges, 3 at default.
- `dir_in` must be stable from one clk before the stb rise until SYNC_STAGES clk after it.
- Minimum strobe high and low time: 2 clk periods each. Faster strobes may lose counts, which is not an error.
- `snap` to `snap_valid`: 1 cycle. Back-to-back snap is allowed every cycle.
- `stb_in` held high across reset release counts once, SYNC_STAGES+1 cycles after release.
- Async reset mid-count clears immediately. There is no partial update.

## Structure
- `trackball_pkg`: `typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e;` and constant `DIR_UP = 1'b0`.
- Sub-module `trackball_axis`, instantiated NUM_AXES times. It holds the sync chains and prev flops for its NUM_PLAYERS channels, the player mux, and the counter with ovf and dir_out.
- Top level: generate loop, snapshot registers, `snap_valid`.

## Test plan
- Reset, player_sel=0, dir=0, 5 clean strobes on axis 0 → cnt[0]=5, 3 cycles after the 5th rise; cnt[1]=0; ovf=0.
- WRAP, dir=1 from 0, 1 strobe → cnt[0]=15, ovf[0]=1; snap → snap_cnt[0]=15, snap_ovf[0]=1, ovf[0]=0 next cycle.
- SAT, 20 up strobes → cnt=15, ovf=1; then 3 down → cnt=12.
- Strobe player 1 axis 1 while player_sel=0 → no count. Switch to player_sel=1 while its stb is held high → no count. Next rise → cnt[1]=1.
- steerclr asserted in the same cycle as a counted edge, cnt=7 → cnt=0, ovf=0. snap in that cycle → snap_cnt=7.
- Assert rstclr_l low mid-sequence with cnt=9 → all outputs 0 immediately. stb held high at release → cnt=1 after 3 cycles.

Source files
------------

// File: rtl/trackball_pkg.sv
// Shared types and constants for the trackball decoder slice.
package trackball_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    localparam logic DIR_UP = 1'b0;

endpackage

// File: rtl/trackball_axis.sv
// One axis: synchronisers and edge trackers for every player's channel,
// player mux, and the up/down counter with sticky overflow and latched direction.
module trackball_axis
    import trackball_pkg::*;
#(
    parameter int        NUM_PLAYERS = 2,
    parameter int        PSEL_W      = 1,
    parameter int        CNT_W       = 4,
    parameter int        SYNC_STAGES = 2,
    parameter cnt_mode_e MODE        = CNT_WRAP
) (
    input  logic                   clk,
    input  logic                   rstclr_l,
    input  logic [NUM_PLAYERS-1:0] dir_raw,
    input  logic [NUM_PLAYERS-1:0] stb_raw,
    input  logic [PSEL_W-1:0]      player_sel,
    input  logic                   steerclr,
    input  logic                   ovf_clr,
    output logic [CNT_W-1:0]       cnt,
    output logic                   ovf,
    output logic                   dir_out
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_PLAYERS-1:0] dir_sync_d [SYNC_STAGES];
    logic [NUM_PLAYERS-1:0] dir_sync_q [SYNC_STAGES];
    logic [NUM_PLAYERS-1:0] stb_sync_d [SYNC_STAGES];
    logic [NUM_PLAYERS-1:0] stb_sync_q [SYNC_STAGES];
    logic [NUM_PLAYERS-1:0] prev_d, prev_q;
    logic [CNT_W-1:0]       cnt_d, cnt_q;
    logic                   ovf_d, ovf_q;
    logic                   dir_out_d, dir_out_q;
    logic                   rise_sel, dir_sel;

    always_comb begin
        dir_sync_d[0] = dir_raw;
        stb_sync_d[0] = stb_raw;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            dir_sync_d[s] = dir_sync_q[s-1];
            stb_sync_d[s] = stb_sync_q[s-1];
        end
        // Every channel is tracked, so switching players never fabricates an edge.
        prev_d = stb_sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        int sel_idx;
        sel_idx  = (int'(player_sel) < NUM_PLAYERS) ? int'(player_sel) : 0;
        rise_sel = 1'b0;
        dir_sel  = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (p == sel_idx) begin
                rise_sel = stb_sync_q[SYNC_STAGES-1][p] & ~prev_q[p];
                dir_sel  = dir_sync_q[SYNC_STAGES-1][p];
            end
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        dir_out_d = dir_out_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        // Overflow is applied after the snapshot clear so a new overflow wins.
        if (rise_sel) begin
            dir_out_d = dir_sel;
            if (dir_sel == DIR_UP) begin
                if (cnt_q == CNT_MAX) begin
                    ovf_d = 1'b1;
                    if (MODE == CNT_WRAP) cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else begin
                if (cnt_q == '0) begin
                    ovf_d = 1'b1;
                    if (MODE == CNT_WRAP) cnt_d = CNT_MAX;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
        end
        if (steerclr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstclr_l) begin
        if (!rstclr_l) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                dir_sync_q[s] <= '0;
                stb_sync_q[s] <= '0;
            end
            prev_q    <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            dir_out_q <= 1'b0;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                dir_sync_q[s] <= dir_sync_d[s];
                stb_sync_q[s] <= stb_sync_d[s];
            end
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            dir_out_q <= dir_out_d;
        end
    end

    assign cnt     = cnt_q;
    assign ovf     = ovf_q;
    assign dir_out = dir_out_q;

endmodule

// File: rtl/trackball_decoder.sv
// Multi-player trackball front end: per-axis counters fed from synchronised
// strobe/direction lines, plus a CPU snapshot latch with one-cycle valid pulse.
module trackball_decoder
    import trackball_pkg::*;
#(
    parameter int        NUM_AXES    = 2,
    parameter int        NUM_PLAYERS = 2,
    parameter int        PSEL_W      = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
    parameter int        CNT_W       = 4,
    parameter int        SYNC_STAGES = 2,
    parameter cnt_mode_e MODE        = CNT_WRAP
) (
    input  logic                          clk,
    input  logic                          rstclr_l,
    input  logic [NUM_PLAYERS*NUM_AXES-1:0] dir_in,
    input  logic [NUM_PLAYERS*NUM_AXES-1:0] stb_in,
    input  logic [PSEL_W-1:0]             player_sel,
    input  logic                          steerclr,
    input  logic                          snap,
    output logic [NUM_AXES-1:0]           dir_out,
    output logic [NUM_AXES*CNT_W-1:0]     cnt,
    output logic [NUM_AXES-1:0]           ovf,
    output logic [NUM_AXES*CNT_W-1:0]     snap_cnt,
    output logic [NUM_AXES-1:0]           snap_ovf,
    output logic                          snap_valid
);

    logic [NUM_AXES*CNT_W-1:0] snap_cnt_d, snap_cnt_q;
    logic [NUM_AXES-1:0]       snap_ovf_d, snap_ovf_q;
    logic                      snap_valid_d, snap_valid_q;

    for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
        logic [NUM_PLAYERS-1:0] dir_ax;
        logic [NUM_PLAYERS-1:0] stb_ax;

        for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_ch
            assign dir_ax[p] = dir_in[p*NUM_AXES+a];
            assign stb_ax[p] = stb_in[p*NUM_AXES+a];
        end

        trackball_axis #(
            .NUM_PLAYERS (NUM_PLAYERS),
            .PSEL_W      (PSEL_W),
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES),
            .MODE        (MODE)
        ) u_axis (
            .clk        (clk),
            .rstclr_l   (rstclr_l),
            .dir_raw    (dir_ax),
            .stb_raw    (stb_ax),
            .player_sel (player_sel),
            .steerclr   (steerclr),
            .ovf_clr    (snap),
            .cnt        (cnt[a*CNT_W +: CNT_W]),
            .ovf        (ovf[a]),
            .dir_out    (dir_out[a])
        );
    end

    // Snapshot captures the registered values, i.e. before this cycle's update.
    always_comb begin
        snap_cnt_d   = snap_cnt_q;
        snap_ovf_d   = snap_ovf_q;
        snap_valid_d = snap;
        if (snap) begin
            snap_cnt_d = cnt;
            snap_ovf_d = ovf;
        end
    end

    always_ff @(posedge clk or negedge rstclr_l) begin
        if (!rstclr_l) begin
            snap_cnt_q   <= '0;
            snap_ovf_q   <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            snap_cnt_q   <= snap_cnt_d;
            snap_ovf_q   <= snap_ovf_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    assign snap_cnt   = snap_cnt_q;
    assign snap_ovf   = snap_ovf_q;
    assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_trackball_decoder.sv
// Bench for trackball_decoder: a wrap-mode and a saturate-mode instance share
// stimulus; table rows, corner-case sequences and a randomized model check.
module tb_trackball_decoder;
    import trackball_pkg::*;

    logic       clk = 1'b0;
    logic       rstclr_l;
    logic [3:0] dir_in;
    logic [3:0] stb_in;
    logic [0:0] player_sel;
    logic       steerclr;
    logic       snap;

    logic [1:0] w_dir_out, s_dir_out;
    logic [7:0] w_cnt, s_cnt;
    logic [1:0] w_ovf, s_ovf;
    logic [7:0] w_snap_cnt, s_snap_cnt;
    logic [1:0] w_snap_ovf, s_snap_ovf;
    logic       w_snap_valid, s_snap_valid;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    trackball_decoder #(.MODE(CNT_WRAP)) dut_wrap (
        .clk(clk), .rstclr_l(rstclr_l), .dir_in(dir_in), .stb_in(stb_in),
        .player_sel(player_sel), .steerclr(steerclr), .snap(snap),
        .dir_out(w_dir_out), .cnt(w_cnt), .ovf(w_ovf),
        .snap_cnt(w_snap_cnt), .snap_ovf(w_snap_ovf), .snap_valid(w_snap_valid)
    );

    trackball_decoder #(.MODE(CNT_SAT)) dut_sat (
        .clk(clk), .rstclr_l(rstclr_l), .dir_in(dir_in), .stb_in(stb_in),
        .player_sel(player_sel), .steerclr(steerclr), .snap(snap),
        .dir_out(s_dir_out), .cnt(s_cnt), .ovf(s_ovf),
        .snap_cnt(s_snap_cnt), .snap_ovf(s_snap_ovf), .snap_valid(s_snap_valid)
    );

    // Reference model: index 0 = wrap instance, 1 = saturate instance.
    int m_cnt [2][2];
    bit m_ovf [2][2];
    bit m_dir [2];
    bit m_dir_known [2];

    typedef struct {
        bit clr; bit sel; int p; int a; bit d; int n; bit chk_dir;
        int w_cnt; bit w_ovf; int s_cnt; bit s_ovf;
    } vec_t;
    vec_t tbl [11];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_pulse();
        steerclr = 1'b1;
        tick();
        steerclr = 1'b0;
        tick();
    endtask

    // Clean strobes: dir set a cycle ahead, 2 high / 2 low, then settle.
    task automatic strobe(input int p, input int a, input bit d, input int n);
        dir_in[p*2+a] = d;
        tick();
        for (int i = 0; i < n; i++) begin
            stb_in[p*2+a] = 1'b1;
            ticks(2);
            stb_in[p*2+a] = 1'b0;
            ticks(2);
        end
        ticks(3);
    endtask

    task automatic model_count(input int a, input bit d);
        for (int m = 0; m < 2; m++) begin
            int v;
            v = m_cnt[m][a] + (d ? -1 : 1);
            if (v < 0 || v > 15) begin
                m_ovf[m][a] = 1'b1;
                if (m == 0) v = (v + 16) % 16;
                else        v = (v < 0) ? 0 : 15;
            end
            m_cnt[m][a] = v;
        end
        m_dir[a]       = d;
        m_dir_known[a] = 1'b1;
    endtask

    function automatic logic [7:0] pk_cnt(input int m);
        return {4'(m_cnt[m][1]), 4'(m_cnt[m][0])};
    endfunction

    function automatic logic [1:0] pk_ovf(input int m);
        return {m_ovf[m][1], m_ovf[m][0]};
    endfunction

    task automatic model_clear();
        for (int m = 0; m < 2; m++)
            for (int a = 0; a < 2; a++) begin
                m_cnt[m][a] = 0;
                m_ovf[m][a] = 1'b0;
            end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " w_cnt"}, 32'(w_cnt), 0);
        chk({tag, " s_cnt"}, 32'(s_cnt), 0);
        chk({tag, " w_ovf"}, 32'(w_ovf), 0);
        chk({tag, " s_ovf"}, 32'(s_ovf), 0);
        chk({tag, " w_dir"}, 32'(w_dir_out), 0);
        chk({tag, " s_dir"}, 32'(s_dir_out), 0);
        chk({tag, " w_snap_cnt"}, 32'(w_snap_cnt), 0);
        chk({tag, " s_snap_cnt"}, 32'(s_snap_cnt), 0);
        chk({tag, " w_snap_ovf"}, 32'(w_snap_ovf), 0);
        chk({tag, " s_snap_valid"}, 32'(s_snap_valid), 0);
        chk({tag, " w_snap_valid"}, 32'(w_snap_valid), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstclr_l   = 1'b0;
        dir_in     = '0;
        stb_in     = '0;
        player_sel = '0;
        steerclr   = 1'b0;
        snap       = 1'b0;
        ticks(2);
        chk_all_zero("reset");
        rstclr_l = 1'b1;
        tick();

        // ---------------- table-driven vectors ----------------
        tbl[0]  = '{1, 0, 0, 0, 0,  5, 1,  5, 0,  5, 0};
        tbl[1]  = '{1, 0, 0, 0, 1,  1, 1, 15, 1,  0, 1};
        tbl[2]  = '{1, 0, 0, 1, 0, 20, 1,  4, 1, 15, 1};
        tbl[3]  = '{0, 0, 0, 1, 1,  3, 1,  1, 1, 12, 1};
        tbl[4]  = '{1, 0, 1, 1, 0,  3, 0,  0, 0,  0, 0};
        tbl[5]  = '{1, 1, 1, 1, 0,  3, 1,  3, 0,  3, 0};
        tbl[6]  = '{1, 1, 0, 0, 0,  2, 0,  0, 0,  0, 0};
        tbl[7]  = '{1, 1, 1, 0, 1,  2, 1, 14, 1,  0, 1};
        tbl[8]  = '{1, 0, 0, 1, 1, 16, 1,  0, 1,  0, 1};
        tbl[9]  = '{1, 0, 0, 0, 0, 16, 1,  0, 1, 15, 1};
        tbl[10] = '{1, 0, 0, 0, 0, 15, 1, 15, 0, 15, 0};
        for (int i = 0; i < 11; i++) begin
            logic [7:0] ew, es;
            logic [1:0] ow, os;
            if (tbl[i].clr) clr_pulse();
            player_sel = tbl[i].sel;
            strobe(tbl[i].p, tbl[i].a, tbl[i].d, tbl[i].n);
            ew = 8'(tbl[i].w_cnt) << (4 * tbl[i].a);
            es = 8'(tbl[i].s_cnt) << (4 * tbl[i].a);
            ow = 2'(tbl[i].w_ovf) << tbl[i].a;
            os = 2'(tbl[i].s_ovf) << tbl[i].a;
            chk($sformatf("tbl%0d w_cnt", i), 32'(w_cnt), 32'(ew));
            chk($sformatf("tbl%0d s_cnt", i), 32'(s_cnt), 32'(es));
            chk($sformatf("tbl%0d w_ovf", i), 32'(w_ovf), 32'(ow));
            chk($sformatf("tbl%0d s_ovf", i), 32'(s_ovf), 32'(os));
            if (tbl[i].chk_dir) begin
                chk($sformatf("tbl%0d w_dir", i), 32'(w_dir_out[tbl[i].a]), 32'(tbl[i].d));
                chk($sformatf("tbl%0d s_dir", i), 32'(s_dir_out[tbl[i].a]), 32'(tbl[i].d));
            end
        end

        // ---------------- latency: count lands on the 3rd edge ----------------
        player_sel = 1'b0;
        clr_pulse();
        dir_in[0] = 1'b0;
        tick();
        stb_in[0] = 1'b1;
        tick();
        chk("lat edge1", 32'(w_cnt), 0);
        tick();
        chk("lat edge2", 32'(w_cnt), 0);
        tick();
        chk("lat edge3", 32'(w_cnt), 1);
        stb_in[0] = 1'b0;
        ticks(4);

        // ---------------- wrap underflow then snapshot ----------------
        clr_pulse();
        strobe(0, 0, 1'b1, 1);
        chk("wrapdn w_cnt", 32'(w_cnt), 32'h0f);
        chk("wrapdn w_ovf", 32'(w_ovf), 1);
        snap = 1'b1;
        tick();
        snap = 1'b0;
        chk("snap w_valid", 32'(w_snap_valid), 1);
        chk("snap w_cnt", 32'(w_snap_cnt), 32'h0f);
        chk("snap w_ovf", 32'(w_snap_ovf), 1);
        chk("snap w_ovf cleared", 32'(w_ovf), 0);
        chk("snap s_ovf cleared", 32'(s_ovf), 0);
        chk("snap keeps w_cnt", 32'(w_cnt), 32'h0f);
        tick();
        chk("snap valid pulse", 32'(w_snap_valid), 0);

        // ---------------- player switch while strobe held high ----------------
        clr_pulse();
        player_sel = 1'b0;
        dir_in[3] = 1'b0;
        tick();
        stb_in[3] = 1'b1;
        ticks(5);
        chk("unsel p1 cnt", 32'(w_cnt), 0);
        player_sel = 1'b1;
        ticks(5);
        chk("switch held cnt", 32'(w_cnt), 0);
        stb_in[3] = 1'b0;
        ticks(3);
        stb_in[3] = 1'b1;
        ticks(4);
        chk("p1 next rise w", 32'(w_cnt), 32'h10);
        chk("p1 next rise s", 32'(s_cnt), 32'h10);
        stb_in[3] = 1'b0;
        ticks(3);

        // ---------------- steerclr + snap on a counted edge ----------------
        player_sel = 1'b0;
        clr_pulse();
        strobe(0, 0, 1'b0, 7);
        chk("pre clr cnt", 32'(w_cnt), 7);
        dir_in[0] = 1'b1;
        tick();
        stb_in[0] = 1'b1;
        ticks(2);
        steerclr = 1'b1;
        snap     = 1'b1;
        tick();
        steerclr = 1'b0;
        snap     = 1'b0;
        chk("clr edge w_cnt", 32'(w_cnt), 0);
        chk("clr edge s_cnt", 32'(s_cnt), 0);
        chk("clr edge ovf", 32'(w_ovf), 0);
        chk("clr edge snap_cnt", 32'(w_snap_cnt), 7);
        chk("clr edge snap_valid", 32'(s_snap_valid), 1);
        chk("clr edge dir_out", 32'(w_dir_out[0]), 1);
        stb_in[0] = 1'b0;
        ticks(4);
        chk("clr edge discarded", 32'(w_cnt), 0);

        // ---------------- async reset mid-sequence ----------------
        clr_pulse();
        strobe(0, 1, 1'b1, 1);
        strobe(0, 0, 1'b0, 9);
        chk("pre rst w_cnt", 32'(w_cnt), 32'hf9);
        snap = 1'b1;
        tick();
        snap = 1'b0;
        stb_in[0] = 1'b1;
        tick();
        #2 rstclr_l = 1'b0;
        #1 chk_all_zero("async rst");
        tick();
        rstclr_l = 1'b1;
        tick();
        chk("rel edge1", 32'(w_cnt), 0);
        tick();
        chk("rel edge2", 32'(s_cnt), 0);
        tick();
        chk("rel edge3 w", 32'(w_cnt), 1);
        chk("rel edge3 s", 32'(s_cnt), 1);
        stb_in[0] = 1'b0;
        ticks(4);

        // ---------------- randomized run against the model ----------------
        clr_pulse();
        model_clear();
        m_dir_known[0] = 1'b1;
        m_dir_known[1] = 1'b0;
        m_dir[0] = 1'b0;
        for (int it = 0; it < 60; it++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op == 0) begin
                clr_pulse();
                model_clear();
                chk($sformatf("rnd%0d clr cnt", it), 32'(w_cnt), 0);
            end else if (op == 1) begin
                snap = 1'b1;
                tick();
                snap = 1'b0;
                chk($sformatf("rnd%0d snap_valid", it), 32'(w_snap_valid), 1);
                chk($sformatf("rnd%0d w_snap_cnt", it), 32'(w_snap_cnt), 32'(pk_cnt(0)));
                chk($sformatf("rnd%0d s_snap_cnt", it), 32'(s_snap_cnt), 32'(pk_cnt(1)));
                chk($sformatf("rnd%0d w_snap_ovf", it), 32'(w_snap_ovf), 32'(pk_ovf(0)));
                chk($sformatf("rnd%0d s_snap_ovf", it), 32'(s_snap_ovf), 32'(pk_ovf(1)));
                for (int m = 0; m < 2; m++) begin
                    m_ovf[m][0] = 1'b0;
                    m_ovf[m][1] = 1'b0;
                end
                tick();
                chk($sformatf("rnd%0d ovf after snap", it), 32'(w_ovf), 0);
            end else begin
                int p, a, n, sel;
                bit d;
                p   = $urandom_range(0, 1);
                a   = $urandom_range(0, 1);
                d   = 1'($urandom_range(0, 1));
                n   = $urandom_range(1, 4);
                sel = $urandom_range(0, 1);
                player_sel = 1'(sel);
                strobe(p, a, d, n);
                if (sel == p) repeat (n) model_count(a, d);
                chk($sformatf("rnd%0d w_cnt", it), 32'(w_cnt), 32'(pk_cnt(0)));
                chk($sformatf("rnd%0d s_cnt", it), 32'(s_cnt), 32'(pk_cnt(1)));
                chk($sformatf("rnd%0d w_ovf", it), 32'(w_ovf), 32'(pk_ovf(0)));
                chk($sformatf("rnd%0d s_ovf", it), 32'(s_ovf), 32'(pk_ovf(1)));
                if (m_dir_known[a])
                    chk($sformatf("rnd%0d dir", it), 32'(w_dir_out[a]), 32'(m_dir[a]));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
